// File: rtl/fir_coef_controller_if.sv
// Coefficient stream handshake between a coefficient source and fir_coef_controller.
// The source drives valid/data; the controller answers with ready.
interface fir_coef_controller_if #(
    parameter int COEFFICIENT_WIDTH = 16
);
    logic                         i_coef_valid;
    logic [COEFFICIENT_WIDTH-1:0] i_coef_data;
    logic                         o_coef_ready;

    modport master (output i_coef_valid, output i_coef_data, input  o_coef_ready);
    modport slave  (input  i_coef_valid, input  i_coef_data, output o_coef_ready);
endinterface

// File: rtl/fir_coef_controller.sv
// Run-time FIR coefficient controller: streams a shadow bank, swaps it to the active bank on sync.
// Optional running coefficient checksum enabled by macro FIR_COEF_CHECKSUM_EN.
module fir_coef_tap #(
    parameter int COEFFICIENT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic                         swap,
    input  logic [COEFFICIENT_WIDTH-1:0] d,
    output logic [COEFFICIENT_WIDTH-1:0] q
);
    logic [COEFFICIENT_WIDTH-1:0] shadow;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow <= '0;
            q      <= '0;
        end else begin
            if (we)   shadow <= d;
            if (swap) q      <= shadow;
        end
    end
endmodule

module fir_coef_controller #(
    parameter int FILTER_LENGTH     = 8,
    parameter int COEFFICIENT_WIDTH = 16,
    parameter int SETTLE_CYCLES     = 2,
    localparam int IDX_W            = (FILTER_LENGTH > 1) ? $clog2(FILTER_LENGTH) : 1
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             i_start,
    input  logic                                             i_abort,
    input  logic                                             i_sync,
    fir_coef_controller_if.slave                             coef,
    output logic [FILTER_LENGTH-1:0][COEFFICIENT_WIDTH-1:0]  coefficients,
    output logic [IDX_W-1:0]                                 o_coef_idx,
    output logic                                             o_busy,
    output logic                                             o_settling,
    output logic                                             o_done,
    output logic [COEFFICIENT_WIDTH+7:0]                     o_checksum
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_ARMED  = 2'd2;
    localparam logic [1:0] S_SETTLE = 2'd3;

    logic [1:0]               state;
    logic [IDX_W-1:0]         idx;
    logic [SETTLE_CYCLES:0]   vld_pipe;
    logic                     xfer, wr_ok, last, swap;
    logic [FILTER_LENGTH-1:0] wr_en;

    assign coef.o_coef_ready = (state == S_LOAD);
    assign xfer  = coef.i_coef_valid && (state == S_LOAD);
    // Abort beats a coincident transfer, so the dropped word never reaches the shadow bank.
    assign wr_ok = xfer && !i_abort;
    assign last  = (idx == IDX_W'(FILTER_LENGTH - 1));
    assign swap  = (state == S_ARMED) && i_sync && !i_abort;

    assign o_coef_idx = idx;
    assign o_busy     = (state != S_IDLE);
    assign o_settling = (state == S_SETTLE);
    assign o_done     = vld_pipe[SETTLE_CYCLES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        state <= S_LOAD;
                        idx   <= '0;
                    end
                end
                S_LOAD: begin
                    if (i_abort) begin
                        state <= S_IDLE;
                        idx   <= '0;
                    end else if (xfer) begin
                        if (last) begin
                            state <= S_ARMED;
                            idx   <= '0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                S_ARMED: begin
                    if (i_abort) begin
                        state <= S_IDLE;
                        idx   <= '0;
                    end else if (i_sync) begin
                        state <= S_SETTLE;
                    end
                end
                default: begin
                    if (vld_pipe[SETTLE_CYCLES-1]) state <= S_IDLE;
                end
            endcase
        end
    end

    // Bit j marks the (j+1)th cycle after the swap edge; the top bit is the done cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vld_pipe <= '0;
        else      vld_pipe <= {vld_pipe[SETTLE_CYCLES-1:0], swap};
    end

    for (genvar t = 0; t < FILTER_LENGTH; t++) begin : g_tap
        assign wr_en[t] = wr_ok && (idx == IDX_W'(t));
        fir_coef_tap #(.COEFFICIENT_WIDTH(COEFFICIENT_WIDTH)) u_tap (
            .clk  (clk),
            .rst  (rst),
            .we   (wr_en[t]),
            .swap (swap),
            .d    (coef.i_coef_data),
            .q    (coefficients[t])
        );
    end

`ifdef FIR_COEF_CHECKSUM_EN
    logic [COEFFICIENT_WIDTH+7:0] cksum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cksum <= '0;
        else if ((state == S_IDLE) && i_start)
            cksum <= '0;
        else if (wr_ok)
            cksum <= cksum + {{8{coef.i_coef_data[COEFFICIENT_WIDTH-1]}}, coef.i_coef_data};
    end

    assign o_checksum = cksum;
`else
    assign o_checksum = '0;
`endif
endmodule

// File: tb/tb_fir_coef_controller.sv
// Randomized self-checking bench for fir_coef_controller against a transaction-level bank model.
module tb_fir_coef_controller;
    localparam int N   = 8;
    localparam int W   = 16;
    localparam int S   = 2;
    localparam int IW  = 3;
    localparam int CKW = N * W;

`ifdef FIR_COEF_CHECKSUM_EN
    localparam logic [W+7:0] S2_CKS = 24'd36;
    localparam logic [W+7:0] S3_CKS = 24'hFFFFF8;
`else
    localparam logic [W+7:0] S2_CKS = '0;
    localparam logic [W+7:0] S3_CKS = '0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, abort = 1'b0, sync = 1'b0;
    logic [N-1:0][W-1:0] coefficients;
    logic [IW-1:0]       idx;
    logic                busy, settling, done;
    logic [W+7:0]        checksum;

    fir_coef_controller_if #(.COEFFICIENT_WIDTH(W)) cif ();

    fir_coef_controller #(
        .FILTER_LENGTH(N), .COEFFICIENT_WIDTH(W), .SETTLE_CYCLES(S)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (start),
        .i_abort      (abort),
        .i_sync       (sync),
        .coef         (cif),
        .coefficients (coefficients),
        .o_coef_idx   (idx),
        .o_busy       (busy),
        .o_settling   (settling),
        .o_done       (done),
        .o_checksum   (checksum)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int done_cnt = 0, done_exp = 0;
    int cks = 0;
    logic [N-1:0][W-1:0] active_m = '0, shadow_m = '0;
    logic signed [W-1:0] vals [N];

    always @(negedge clk) if (done) done_cnt++;

    task automatic chk(input string tag, input logic [CKW-1:0] got, input logic [CKW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W+7:0] cks_exp();
`ifdef FIR_COEF_CHECKSUM_EN
        return cks[W+7:0];
`else
        return '0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_vals();
        for (int i = 0; i < N; i++) vals[i] = W'($urandom);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        cks = 0;
        chk("start_busy", busy, 1);
        chk("start_ready", cif.o_coef_ready, 1);
        chk("start_idx", idx, 0);
        chk("start_cks", checksum, cks_exp());
    endtask

    // vmode: 0 back-to-back, 1 toggled valid, 2 random valid; abort_at: tap index to abort at (-1 none)
    task automatic stream(input int vmode, input int abort_at, output bit aborted);
        int  k = 0;
        int  guard = 0;
        bit  v, ab;
        aborted = 1'b0;
        while (k < N) begin
            v  = (vmode == 0) ? 1'b1 : (vmode == 1) ? (guard % 2 == 0) : ($urandom_range(0, 3) != 0);
            ab = (k == abort_at);
            cif.i_coef_valid = v;
            cif.i_coef_data  = vals[k];
            sync  = ($urandom_range(0, 3) == 0);
            start = ($urandom_range(0, 7) == 0);
            abort = ab;
            chk("ld_ready", cif.o_coef_ready, 1);
            chk("ld_idx", idx, k);
            chk("ld_coef", coefficients, active_m);
            tick();
            {sync, start, abort} = 3'b000;
            if (ab) begin
                aborted = 1'b1;
                break;
            end
            if (v) begin
                shadow_m[k] = vals[k];
                cks += int'(vals[k]);
                k++;
            end
            guard++;
            if (guard > 200) begin
                chk("stream_timeout", guard, 0);
                break;
            end
        end
        cif.i_coef_valid = 1'b0;
        chk(aborted ? "ab_busy" : "armed_busy", busy, aborted ? 0 : 1);
        chk("post_ready", cif.o_coef_ready, 0);
        chk("post_idx", idx, 0);
        chk("post_coef", coefficients, active_m);
        chk("post_cks", checksum, cks_exp());
    endtask

    task automatic swap_settle(input int delay);
        repeat (delay) begin
            chk("arm_busy", busy, 1);
            chk("arm_settling", settling, 0);
            chk("arm_coef", coefficients, active_m);
            tick();
        end
        sync = 1'b1;
        tick();
        sync = 1'b0;
        active_m = shadow_m;
        chk("swap_coef", coefficients, active_m);
        for (int i = 0; i < S; i++) begin
            chk("settle_hi", settling, 1);
            chk("settle_busy", busy, 1);
            chk("settle_nodone", done, 0);
            abort = $urandom_range(0, 1);
            tick();
            abort = 1'b0;
        end
        chk("done_pulse", done, 1);
        chk("done_idle", busy, 0);
        chk("done_settling", settling, 0);
        chk("done_coef", coefficients, active_m);
        chk("done_cks", checksum, cks_exp());
        done_exp++;
    endtask

    task automatic abort_armed();
        abort = 1'b1;
        sync  = 1'b1;
        tick();
        {abort, sync} = 2'b00;
        chk("abarm_busy", busy, 0);
        chk("abarm_coef", coefficients, active_m);
        chk("abarm_done", done, 0);
        tick();
        chk("abarm_done2", done, 0);
    endtask

    task automatic stray_sync();
        sync = 1'b1;
        tick();
        sync = 1'b0;
        chk("stray_busy", busy, 0);
        chk("stray_coef", coefficients, active_m);
    endtask

    initial begin
        bit ab;
        int mode;
        cif.i_coef_valid = 1'b0;
        cif.i_coef_data  = '0;
        #12;
        chk("rst_coef", coefficients, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cif.o_coef_ready, 0);
        chk("rst_idx", idx, 0);
        chk("rst_done", done, 0);
        chk("rst_cks", checksum, 0);
        rst = 1'b1;
        tick();

        // back-to-back 1..8, sync 5 cycles after arming
        for (int i = 0; i < N; i++) vals[i] = W'(i + 1);
        do_start();
        stream(0, -1, ab);
        swap_settle(5);
        chk("s2_cks", checksum, S2_CKS);
        tick();
        chk("s2_done_once", done, 0);

        // reset after 3 transfers discards everything including the active bank
        rand_vals();
        do_start();
        cif.i_coef_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cif.i_coef_data = vals[i];
            tick();
        end
        cif.i_coef_valid = 1'b0;
        chk("midrst_idx_pre", idx, 3);
        rst = 1'b0;
        #1;
        active_m = '0;
        chk("midrst_coef", coefficients, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_idx", idx, 0);
        chk("midrst_ready", cif.o_coef_ready, 0);
        chk("midrst_cks", checksum, 0);
        #1 rst = 1'b1;
        tick();

        // toggled valid with all -1
        for (int i = 0; i < N; i++) vals[i] = '1;
        do_start();
        stream(1, -1, ab);
        swap_settle(2);
        chk("s3_cks", checksum, S3_CKS);
        tick();

        // abort + sync in ARMED, then a clean restart
        rand_vals();
        do_start();
        stream(2, -1, ab);
        abort_armed();
        rand_vals();
        do_start();
        stream(0, -1, ab);
        swap_settle(1);
        tick();

        // abort colliding with the final transfer
        rand_vals();
        do_start();
        stream(0, N - 1, ab);
        chk("s5_aborted", ab, 1);
        stray_sync();
        chk("s5_done", done, 0);

        repeat (30) begin
            rand_vals();
            mode = $urandom_range(0, 3);
            do_start();
            case (mode)
                0: begin
                    stream($urandom_range(0, 2), -1, ab);
                    swap_settle($urandom_range(0, 4));
                    if ($urandom_range(0, 1) == 1) tick();
                end
                1: begin
                    stream(2, $urandom_range(0, N - 1), ab);
                    stray_sync();
                end
                2: begin
                    stream($urandom_range(0, 2), -1, ab);
                    abort_armed();
                end
                default: begin
                    stream(0, N - 1, ab);
                    stray_sync();
                end
            endcase
        end

        tick();
        tick();
        chk("done_count", done_cnt, done_exp);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
